// File: rtl/mux_pkg.sv
// Shared definitions for the mux operand sequencer: FSM state encoding,
// the default operand width, and the phase counter width helper.
package mux_pkg;

   localparam int MUX_WIDTH = 4;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      RUN    = 2'd2
   } state_e;

   // A hold of one cycle still needs a 1-bit counter so the compare stays legal
   function automatic int cntWidth(input int hold);
      return (hold <= 1) ? 1 : $clog2(hold);
   endfunction

endpackage

// File: rtl/mux_operand_sequencer_phase_counter.sv
// Phase counter: counts enabled cycles and pulses wrap on the last one of a
// phase, restarting from zero; clear forces zero and suppresses the wrap.
module phase_counter
   import mux_pkg::*;
#(
   parameter int HOLD_CYCLES = 8,
   parameter int CW          = cntWidth(HOLD_CYCLES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign wrap = en && !clear && (cnt_q == LAST);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (wrap) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_operand_sequencer.sv
// Loads operands A then B over valid/ready, then alternates the select S
// every HOLD_CYCLES unpaused cycles until clear or reset.
module mux_operand_sequencer
   import mux_pkg::*;
#(
   parameter int WIDTH       = MUX_WIDTH,
   parameter int HOLD_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             pause,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             S,
   output logic             run,
   output logic             toggle
);

   localparam int CW = cntWidth(HOLD_CYCLES);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             s_q, s_d;
   logic             run_q, run_d;
   logic             toggle_q, toggle_d;

   logic             transfer;
   logic             phaseEn;
   logic             phaseClear;
   logic             wrap;
   logic [CW-1:0]    cnt_unused;

   // Ready depends on the state register alone so it never loops back through din_valid
   assign din_ready  = (state_q != RUN);
   assign transfer   = din_valid && din_ready;
   assign phaseEn    = (state_q == RUN) && !pause;
   assign phaseClear = clear || ((state_q == LOAD_B) && transfer);

   phase_counter #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .CW         (CW)
   ) u_phase_counter (
      .clk  (clk),
      .rst  (rst),
      .clear(phaseClear),
      .en   (phaseEn),
      .cnt  (cnt_unused),
      .wrap (wrap)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      s_d      = s_q;
      run_d    = run_q;
      toggle_d = 1'b0;
      if (clear) begin
         state_d = LOAD_A;
         run_d   = 1'b0;
         s_d     = 1'b0;
      end else begin
         unique case (state_q)
            LOAD_A: begin
               if (transfer) begin
                  a_d     = din;
                  state_d = LOAD_B;
               end
            end
            LOAD_B: begin
               if (transfer) begin
                  b_d     = din;
                  s_d     = 1'b0;
                  run_d   = 1'b1;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (wrap) begin
                  s_d      = ~s_q;
                  toggle_d = 1'b1;
               end
            end
            default: begin
               state_d = LOAD_A;
               run_d   = 1'b0;
               s_d     = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= LOAD_A;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= 1'b0;
         run_q    <= 1'b0;
         toggle_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         s_q      <= s_d;
         run_q    <= run_d;
         toggle_q <= toggle_d;
      end
   end

   assign A      = a_q;
   assign B      = b_q;
   assign S      = s_q;
   assign run    = run_q;
   assign toggle = toggle_q;

endmodule

// File: tb/tb_mux_operand_sequencer.sv
// Bench for mux_operand_sequencer: a directed vector table on a HOLD_CYCLES=8
// instance, hand sequences for HOLD_CYCLES=1 and async reset, then random traffic.
module tb_mux_operand_sequencer;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       clear     = 1'b0;
   logic       pause     = 1'b0;
   logic [3:0] din       = 4'h0;
   logic       din_valid = 1'b0;

   logic [3:0] a8, b8, a1, b1;
   logic       s8, run8, tog8, rdy8;
   logic       s1, run1, tog1, rdy1;
   logic [3:0] muxY;

   int nChecks = 0;
   int nPass   = 0;
   logic modelCheckEn = 1'b0;

   always #5 clk = ~clk;

   mux_operand_sequencer #(.WIDTH(4), .HOLD_CYCLES(8)) dut8 (
      .clk(clk), .rst(rst), .clear(clear), .pause(pause), .din(din),
      .din_valid(din_valid), .din_ready(rdy8), .A(a8), .B(b8), .S(s8),
      .run(run8), .toggle(tog8)
   );

   mux_operand_sequencer #(.WIDTH(4), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .clear(clear), .pause(pause), .din(din),
      .din_valid(din_valid), .din_ready(rdy1), .A(a1), .B(b1), .S(s1),
      .run(run1), .toggle(tog1)
   );

   // Downstream 2:1 mux as it would sit in the integration top
   assign muxY = s8 ? b8 : a8;

   // Reference model: counts unpaused RUN cycles and derives S/toggle arithmetically
   int         hold[2]    = '{8, 1};
   int         mLoaded[2] = '{0, 0};
   int         mActive[2] = '{0, 0};
   logic [3:0] mA[2]      = '{4'h0, 4'h0};
   logic [3:0] mB[2]      = '{4'h0, 4'h0};
   logic       mS[2]      = '{1'b0, 1'b0};
   logic       mTog[2]    = '{1'b0, 1'b0};

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            mLoaded[k] <= 0; mActive[k] <= 0; mA[k] <= 4'h0; mB[k] <= 4'h0;
            mS[k] <= 1'b0; mTog[k] <= 1'b0;
         end else if (clear) begin
            mLoaded[k] <= 0; mActive[k] <= 0; mS[k] <= 1'b0; mTog[k] <= 1'b0;
         end else if (mLoaded[k] == 0) begin
            if (din_valid) begin
               mA[k] <= din; mLoaded[k] <= 1;
            end
         end else if (mLoaded[k] == 1) begin
            if (din_valid) begin
               mB[k] <= din; mLoaded[k] <= 2; mActive[k] <= 0;
               mS[k] <= 1'b0; mTog[k] <= 1'b0;
            end
         end else if (!pause) begin
            mActive[k] <= mActive[k] + 1;
            mTog[k]    <= ((mActive[k] + 1) % hold[k]) == 0;
            mS[k]      <= (((mActive[k] + 1) / hold[k]) % 2) == 1;
         end else begin
            mTog[k] <= 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      nChecks++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         nPass++;
   endtask

   task automatic applyStimulus(input logic c, input logic p, input logic v, input logic [3:0] d);
      clear     = c;
      pause     = p;
      din_valid = v;
      din       = d;
   endtask

   always @(negedge clk) begin
      if (modelCheckEn) begin
         checkOutput("m8.A",   {4'h0, a8},   {4'h0, mA[0]});
         checkOutput("m8.B",   {4'h0, b8},   {4'h0, mB[0]});
         checkOutput("m8.S",   {7'h0, s8},   {7'h0, mS[0]});
         checkOutput("m8.run", {7'h0, run8}, {7'h0, mLoaded[0] == 2});
         checkOutput("m8.tog", {7'h0, tog8}, {7'h0, mTog[0]});
         checkOutput("m8.rdy", {7'h0, rdy8}, {7'h0, mLoaded[0] != 2});
         checkOutput("m1.A",   {4'h0, a1},   {4'h0, mA[1]});
         checkOutput("m1.B",   {4'h0, b1},   {4'h0, mB[1]});
         checkOutput("m1.S",   {7'h0, s1},   {7'h0, mS[1]});
         checkOutput("m1.run", {7'h0, run1}, {7'h0, mLoaded[1] == 2});
         checkOutput("m1.tog", {7'h0, tog1}, {7'h0, mTog[1]});
         checkOutput("m1.rdy", {7'h0, rdy1}, {7'h0, mLoaded[1] != 2});
      end
   end

   typedef struct {
      int         n;
      logic       clr, pau, vld;
      logic [3:0] d;
      logic [3:0] eA, eB, eY;
      logic       eS, eRun, eTog, eRdy;
   } vec_t;

   vec_t vecs[19];

   initial begin
      //         n  clr pau vld din   A     B     Y     S     run   tog   rdy
      vecs[0]  = '{1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1, 0, 0, 1, 4'hA, 4'hA, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{5, 0, 0, 0, 4'h7, 4'hA, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{1, 0, 0, 1, 4'h5, 4'hA, 4'h5, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{7, 0, 0, 1, 4'hF, 4'hA, 4'h5, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1, 0, 0, 0, 4'h0, 4'hA, 4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{1, 0, 0, 0, 4'h0, 4'hA, 4'h5, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{7, 0, 0, 0, 4'h0, 4'hA, 4'h5, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{4, 0, 0, 0, 4'h0, 4'hA, 4'h5, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{3, 0, 1, 0, 4'h0, 4'hA, 4'h5, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{3, 0, 0, 0, 4'h0, 4'hA, 4'h5, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1, 0, 0, 0, 4'h0, 4'hA, 4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[12] = '{1, 1, 1, 1, 4'h3, 4'hA, 4'h5, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{1, 0, 0, 1, 4'h3, 4'h3, 4'h5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{1, 0, 0, 1, 4'hC, 4'h3, 4'hC, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{8, 0, 0, 0, 4'h0, 4'h3, 4'hC, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[16] = '{1, 1, 0, 1, 4'h9, 4'h3, 4'hC, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[17] = '{1, 1, 0, 1, 4'h9, 4'h3, 4'hC, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[18] = '{1, 0, 0, 0, 4'h0, 4'h3, 4'hC, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1};

      applyStimulus(0, 0, 0, 4'h0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      modelCheckEn = 1'b1;

      // Directed table on the HOLD_CYCLES=8 instance
      for (int i = 0; i < 19; i++) begin
         applyStimulus(vecs[i].clr, vecs[i].pau, vecs[i].vld, vecs[i].d);
         repeat (vecs[i].n) @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("vec%0d.A", i),   {4'h0, a8},   {4'h0, vecs[i].eA});
         checkOutput($sformatf("vec%0d.B", i),   {4'h0, b8},   {4'h0, vecs[i].eB});
         checkOutput($sformatf("vec%0d.Y", i),   {4'h0, muxY}, {4'h0, vecs[i].eY});
         checkOutput($sformatf("vec%0d.S", i),   {7'h0, s8},   {7'h0, vecs[i].eS});
         checkOutput($sformatf("vec%0d.run", i), {7'h0, run8}, {7'h0, vecs[i].eRun});
         checkOutput($sformatf("vec%0d.tog", i), {7'h0, tog8}, {7'h0, vecs[i].eTog});
         checkOutput($sformatf("vec%0d.rdy", i), {7'h0, rdy8}, {7'h0, vecs[i].eRdy});
      end

      // HOLD_CYCLES=1: S flips every cycle and toggle stays high once running
      applyStimulus(0, 0, 1, 4'h6);
      @(posedge clk); @(negedge clk);
      applyStimulus(0, 0, 1, 4'h9);
      @(posedge clk); @(negedge clk);
      checkOutput("h1.run0", {7'h0, run1}, 8'h1);
      checkOutput("h1.S0",   {7'h0, s1},   8'h0);
      applyStimulus(0, 0, 0, 4'h0);
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); @(negedge clk);
         checkOutput($sformatf("h1.S%0d", i),   {7'h0, s1},   {7'h0, 1'(i % 2)});
         checkOutput($sformatf("h1.tog%0d", i), {7'h0, tog1}, 8'h1);
      end

      // Async reset between edges must clear outputs before the next edge
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("ar.A8",   {4'h0, a8},   8'h0);
      checkOutput("ar.B8",   {4'h0, b8},   8'h0);
      checkOutput("ar.run8", {7'h0, run8}, 8'h0);
      checkOutput("ar.S1",   {7'h0, s1},   8'h0);
      checkOutput("ar.tog1", {7'h0, tog1}, 8'h0);
      checkOutput("ar.rdy8", {7'h0, rdy8}, 8'h1);
      #1 rst = 1'b0;
      @(negedge clk);

      // Random traffic against the reference model
      for (int i = 0; i < 800; i++) begin
         applyStimulus(($urandom % 25) == 0, ($urandom % 4) == 0,
                       ($urandom % 3) != 0, 4'($urandom));
         @(posedge clk);
         @(negedge clk);
      end

      modelCheckEn = 1'b0;
      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
